// File: rtl/stfq_rank_computer_pkg.sv
// Shared types for the STFQ rank computer.
//   priority_t          : rank / virtual-time type shared with flow_pifo
//   MAX_PACKET_PRIORITY : saturation ceiling for ranks
//   prio_max()          : unsigned max of two ranks
package stfq_rank_computer_pkg;

  localparam int NUM_FLOWS_DEF   = 8;
  localparam int PRIO_W          = 16;
  localparam int LEN_WIDTH_DEF   = 11;
  localparam int SHIFT_WIDTH_DEF = 3;

  typedef logic [PRIO_W-1:0]          priority_t;
  typedef logic [LEN_WIDTH_DEF-1:0]   pkt_len_t;
  typedef logic [SHIFT_WIDTH_DEF-1:0] weight_shift_t;

  localparam priority_t MAX_PACKET_PRIORITY = '1;

  function automatic priority_t prio_max(input priority_t a, input priority_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stfq_flow_table.sv
// Per-flow state table: NUM_FLOWS entries of {last_finish, shift}.
//   clk, reset          : clock, async active-low clear of every entry
//   rd_idx              : async read port -> rd_finish, rd_shift
//   fin_we/idx/data     : finish-time write port
//   sh_we/idx/data      : weight-shift write port (independent of finish)
// Out-of-range indices (non power-of-two NUM_FLOWS) read 0 and are not written.
module stfq_flow_table
  import stfq_rank_computer_pkg::*;
#(
  parameter int NUM_FLOWS   = NUM_FLOWS_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
  parameter int FID_W       = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [FID_W-1:0]       rd_idx,
  output priority_t              rd_finish,
  output logic [SHIFT_WIDTH-1:0] rd_shift,
  input  logic                   fin_we,
  input  logic [FID_W-1:0]       fin_idx,
  input  priority_t              fin_data,
  input  logic                   sh_we,
  input  logic [FID_W-1:0]       sh_idx,
  input  logic [SHIFT_WIDTH-1:0] sh_data
);

  logic [NUM_FLOWS-1:0][PRIO_W-1:0]      finish_q;
  logic [NUM_FLOWS-1:0][SHIFT_WIDTH-1:0] shift_q;

  logic rd_ok, fin_ok, sh_ok;
  assign rd_ok  = int'(rd_idx)  < NUM_FLOWS;
  assign fin_ok = int'(fin_idx) < NUM_FLOWS;
  assign sh_ok  = int'(sh_idx)  < NUM_FLOWS;

  assign rd_finish = rd_ok ? finish_q[rd_idx] : '0;
  assign rd_shift  = rd_ok ? shift_q[rd_idx]  : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      finish_q <= '0;
      shift_q  <= '0;
    end else begin
      if (fin_we && fin_ok) finish_q[fin_idx] <= fin_data;
      if (sh_we && sh_ok)   shift_q[sh_idx]   <= sh_data;
    end
  end

endmodule

// File: rtl/stfq_rank_computer.sv
// Start-time fair-queueing rank computer feeding flow_pifo.
//   Arrival (flow, len) -> 2 cycles later o__enqueue with
//   rank = max(vt, last_finish[flow]); last_finish[flow] <= sat(rank + (len << shift[flow])).
//   Ports:
//     clk, reset (async active-low)
//     i__arrival_*   : packet arrivals, accepted every cycle
//     i__cfg_*       : per-flow weight shift writes
//     i__dequeue*    : snooped flow_pifo dequeue, advances virtual time
//     o__enqueue*    : rank/flow to flow_pifo (qualify with o__enqueue)
//     o__virtual_time: current virtual time
module stfq_rank_computer
  import stfq_rank_computer_pkg::*;
#(
  parameter  int NUM_FLOWS   = NUM_FLOWS_DEF,
  parameter  int LEN_WIDTH   = LEN_WIDTH_DEF,
  parameter  int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
  localparam int FID_W       = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i__arrival_valid,
  input  logic [FID_W-1:0]       i__arrival_flow_id,
  input  logic [LEN_WIDTH-1:0]   i__arrival_length,
  input  logic                   i__cfg_valid,
  input  logic [FID_W-1:0]       i__cfg_flow_id,
  input  logic [SHIFT_WIDTH-1:0] i__cfg_shift,
  input  logic                   i__dequeue,
  input  priority_t              i__dequeue_priority,
  output logic                   o__enqueue,
  output priority_t              o__enqueue_priority,
  output logic [FID_W-1:0]       o__enqueue_flow_id,
  output priority_t              o__virtual_time
);

  localparam int COST_W = LEN_WIDTH + (1 << SHIFT_WIDTH) - 1;
  // One extra bit over the wider operand so the carry is visible for saturation.
  localparam int SUM_W  = ((COST_W > PRIO_W) ? COST_W : PRIO_W) + 1;

  // vld_pipe[0]: S1 holds a packet; vld_pipe[1]: output regs valid.
  logic [1:0]             vld_pipe;
  logic [FID_W-1:0]       s1_fid;
  logic [LEN_WIDTH-1:0]   s1_len;
  priority_t              vt;

  priority_t              rd_finish;
  logic [SHIFT_WIDTH-1:0] rd_shift;
  priority_t              start;
  priority_t              finish;
  logic [COST_W-1:0]      cost;
  logic [SUM_W-1:0]       sum;

  stfq_flow_table #(
    .NUM_FLOWS   (NUM_FLOWS),
    .SHIFT_WIDTH (SHIFT_WIDTH),
    .FID_W       (FID_W)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (s1_fid),
    .rd_finish (rd_finish),
    .rd_shift  (rd_shift),
    .fin_we    (vld_pipe[0]),
    .fin_idx   (s1_fid),
    .fin_data  (finish),
    .sh_we     (i__cfg_valid),
    .sh_idx    (i__cfg_flow_id),
    .sh_data   (i__cfg_shift)
  );

  // S1 datapath. The table write for the previous packet lands on the edge
  // that loads this one, so same-flow back-to-back needs no bypass. A cfg
  // write in this cycle only lands at the edge, so S1 sees the old shift.
  always_comb begin
    start  = prio_max(vt, rd_finish);
    cost   = COST_W'(s1_len) << rd_shift;
    sum    = SUM_W'(start) + SUM_W'(cost);
    finish = (sum > SUM_W'(MAX_PACKET_PRIORITY)) ? MAX_PACKET_PRIORITY
                                                 : sum[PRIO_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe            <= '0;
      s1_fid              <= '0;
      s1_len              <= '0;
      vt                  <= '0;
      o__enqueue_priority <= '0;
      o__enqueue_flow_id  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], i__arrival_valid};
      if (i__arrival_valid) begin
        s1_fid <= i__arrival_flow_id;
        s1_len <= i__arrival_length;
      end
      // Output regs hold their last value when idle.
      if (vld_pipe[0]) begin
        o__enqueue_priority <= start;
        o__enqueue_flow_id  <= s1_fid;
      end
      if (i__dequeue && (i__dequeue_priority > vt))
        vt <= i__dequeue_priority;
    end
  end

  assign o__enqueue      = vld_pipe[1];
  assign o__virtual_time = vt;

endmodule
